// File: rtl/edulent_mem_responder.sv
// 256x8 responder for the Edulent MA/MD bus with a valid/ready program loader; CPU held until loading ends.
// Read latency 1 cycle (read-first); loader backpressured by o_load_ready, which is only high in LOAD.
module edulent_mem_responder #(
    parameter int ADDR_W    = 8,
    parameter int DATA_W    = 8,
    parameter     INIT_FILE = ""
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [ADDR_W-1:0] i_mem_addr,
    input  logic              i_mem_write_enable,
    input  logic [DATA_W-1:0] i_mem_data_write,
    output logic [DATA_W-1:0] o_mem_data_read,
    input  logic              i_load_valid,
    output logic              o_load_ready,
    input  logic [DATA_W-1:0] i_load_data,
    input  logic              i_load_last,
    input  logic              i_load_start,
    output logic              o_load_done,
    output logic              o_cpu_hold
);

    localparam int              DEPTH    = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    typedef enum logic {
        S_LOAD = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic [ADDR_W-1:0] load_addr_q;
    logic [ADDR_W-1:0] load_addr_d;
    logic              load_exit;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_dat;

    logic [DATA_W-1:0] mem [0:DEPTH-1];

    // Single RAM write port shared between the loader (LOAD) and the CPU (RUN).
    always_comb begin
        state_d     = state_q;
        load_addr_d = load_addr_q;
        load_exit   = 1'b0;
        wr_en       = 1'b0;
        wr_addr     = i_mem_addr;
        wr_dat      = i_mem_data_write;
        case (state_q)
            S_LOAD: begin
                if (i_load_valid && o_load_ready) begin
                    wr_en       = 1'b1;
                    wr_addr     = load_addr_q;
                    wr_dat      = i_load_data;
                    load_addr_d = load_addr_q + ADDR_ONE;
                    if (i_load_last || (load_addr_q == '1)) begin
                        load_exit = 1'b1;
                        state_d   = S_RUN;
                    end
                end
            end
            S_RUN: begin
                wr_en = i_mem_write_enable;
                if (i_load_start) begin
                    state_d     = S_LOAD;
                    load_addr_d = '0;
                end
            end
            default: begin
                state_d     = S_LOAD;
                load_addr_d = '0;
            end
        endcase
    end

    // Ready and hold are registered from the next state so both change on the exit/re-entry edge.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q         <= S_LOAD;
            load_addr_q     <= '0;
            o_load_ready    <= 1'b0;
            o_load_done     <= 1'b0;
            o_cpu_hold      <= 1'b1;
            o_mem_data_read <= '0;
        end else begin
            state_q      <= state_d;
            load_addr_q  <= load_addr_d;
            o_load_ready <= (state_d == S_LOAD);
            o_load_done  <= load_exit;
            o_cpu_hold   <= (state_d == S_LOAD);
            if (state_q == S_RUN) begin
                o_mem_data_read <= mem[i_mem_addr];
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_dat;
        end
    end

endmodule

// File: tb/tb_edulent_mem_responder.sv
// Bench for edulent_mem_responder: table of RUN bus vectors plus hand sequences for load, wrap, reset and reload.
module tb_edulent_mem_responder;

    logic       i_clk = 1'b0;
    logic       i_rst;
    logic [7:0] i_mem_addr;
    logic       i_mem_write_enable;
    logic [7:0] i_mem_data_write;
    logic [7:0] o_mem_data_read;
    logic       i_load_valid;
    logic       o_load_ready;
    logic [7:0] i_load_data;
    logic       i_load_last;
    logic       i_load_start;
    logic       o_load_done;
    logic       o_cpu_hold;

    int total = 0;
    int bad   = 0;
    logic [7:0] exp_q[$];

    edulent_mem_responder #(.ADDR_W(8), .DATA_W(8), .INIT_FILE("")) dut (
        .i_clk              (i_clk),
        .i_rst              (i_rst),
        .i_mem_addr         (i_mem_addr),
        .i_mem_write_enable (i_mem_write_enable),
        .i_mem_data_write   (i_mem_data_write),
        .o_mem_data_read    (o_mem_data_read),
        .i_load_valid       (i_load_valid),
        .o_load_ready       (o_load_ready),
        .i_load_data        (i_load_data),
        .i_load_last        (i_load_last),
        .i_load_start       (i_load_start),
        .o_load_done        (o_load_done),
        .o_cpu_hold         (o_cpu_hold)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [7:0] addr;
        logic       we;
        logic [7:0] wd;
        logic       chk;
        logic [7:0] exp;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    // Drive one RUN bus cycle; the expected read is queued at drive time and popped once the edge has passed.
    task automatic bus_cycle(input logic [7:0] a, input logic we, input logic [7:0] wd,
                             input logic chk, input logic [7:0] exp, input string name);
        logic [7:0] e;
        i_mem_addr         = a;
        i_mem_write_enable = we;
        i_mem_data_write   = wd;
        if (chk) exp_q.push_back(exp);
        step();
        i_mem_write_enable = 1'b0;
        if (chk) begin
            if (exp_q.size() == 0) begin
                check({name, "_queue"}, 32'd0, 32'd1);
            end else begin
                e = exp_q.pop_front();
                check(name, {24'd0, o_mem_data_read}, {24'd0, e});
            end
        end
    endtask

    task automatic load_byte(input logic [7:0] d, input logic last);
        i_load_valid = 1'b1;
        i_load_data  = d;
        i_load_last  = last;
        step();
        i_load_valid = 1'b0;
        i_load_last  = 1'b0;
    endtask

    task automatic start_load();
        i_load_start = 1'b1;
        step();
        i_load_start = 1'b0;
    endtask

    initial begin
        vecs[0] = '{addr: 8'h02, we: 1'b0, wd: 8'h00, chk: 1'b1, exp: 8'h33};
        vecs[1] = '{addr: 8'h00, we: 1'b0, wd: 8'h00, chk: 1'b1, exp: 8'h11};
        vecs[2] = '{addr: 8'h01, we: 1'b0, wd: 8'h00, chk: 1'b1, exp: 8'h22};
        vecs[3] = '{addr: 8'h40, we: 1'b1, wd: 8'h77, chk: 1'b0, exp: 8'h00};
        vecs[4] = '{addr: 8'h40, we: 1'b1, wd: 8'hA5, chk: 1'b1, exp: 8'h77};
        vecs[5] = '{addr: 8'h40, we: 1'b0, wd: 8'h00, chk: 1'b1, exp: 8'hA5};
        vecs[6] = '{addr: 8'h02, we: 1'b0, wd: 8'h00, chk: 1'b1, exp: 8'h33};

        i_rst = 1'b1;
        i_mem_addr = 8'h00;
        i_mem_write_enable = 1'b0;
        i_mem_data_write = 8'h00;
        i_load_valid = 1'b0;
        i_load_data = 8'h00;
        i_load_last = 1'b0;
        i_load_start = 1'b0;
        step();
        step();
        check("rst_rd",    {24'd0, o_mem_data_read}, 32'h0);
        check("rst_ready", {31'd0, o_load_ready}, 32'd0);
        check("rst_done",  {31'd0, o_load_done}, 32'd0);
        check("rst_hold",  {31'd0, o_cpu_hold}, 32'd1);

        // Initial load of three bytes
        i_rst = 1'b0;
        step();
        check("t1_ready", {31'd0, o_load_ready}, 32'd1);
        load_byte(8'h11, 1'b0);
        load_byte(8'h22, 1'b0);
        check("t1_nodone", {31'd0, o_load_done}, 32'd0);
        check("t1_hold_ld", {31'd0, o_cpu_hold}, 32'd1);
        load_byte(8'h33, 1'b1);
        check("t1_done",  {31'd0, o_load_done}, 32'd1);
        check("t1_hold",  {31'd0, o_cpu_hold}, 32'd0);
        check("t1_ready0", {31'd0, o_load_ready}, 32'd0);
        step();
        check("t1_done_pulse", {31'd0, o_load_done}, 32'd0);

        // RUN reads/writes from the vector table, including read-first collision
        for (int i = 0; i < 7; i++) begin
            bus_cycle(vecs[i].addr, vecs[i].we, vecs[i].wd, vecs[i].chk, vecs[i].exp,
                      $sformatf("vec%0d", i));
        end
        check("t2_hold_run", {31'd0, o_cpu_hold}, 32'd0);

        // Reload request with a concurrent CPU write
        i_mem_addr = 8'h10;
        i_mem_write_enable = 1'b1;
        i_mem_data_write = 8'h5A;
        start_load();
        i_mem_write_enable = 1'b0;
        check("t6_hold",  {31'd0, o_cpu_hold}, 32'd1);
        check("t6_ready", {31'd0, o_load_ready}, 32'd1);
        load_byte(8'hC3, 1'b1);
        check("t6_done", {31'd0, o_load_done}, 32'd1);
        bus_cycle(8'h00, 1'b0, 8'h00, 1'b1, 8'hC3, "t6_rd00");
        bus_cycle(8'h10, 1'b0, 8'h00, 1'b1, 8'h5A, "t6_rd10");

        // Full 256-byte load without last
        start_load();
        for (int i = 0; i < 256; i++) begin
            load_byte(8'(i) ^ 8'h5A, 1'b0);
            if (i == 254) check("t4_nodone254", {31'd0, o_load_done}, 32'd0);
        end
        check("t4_done",   {31'd0, o_load_done}, 32'd1);
        check("t4_hold",   {31'd0, o_cpu_hold}, 32'd0);
        check("t4_ready0", {31'd0, o_load_ready}, 32'd0);
        bus_cycle(8'hFF, 1'b0, 8'h00, 1'b1, 8'hA5, "t4_rdFF");
        bus_cycle(8'h00, 1'b0, 8'h00, 1'b1, 8'h5A, "t4_rd00");
        bus_cycle(8'h80, 1'b0, 8'h00, 1'b1, 8'hDA, "t4_rd80");

        // Reset in the middle of a reload
        start_load();
        load_byte(8'hE1, 1'b0);
        load_byte(8'hE2, 1'b0);
        i_rst = 1'b1;
        #1;
        check("t5_ready_rst", {31'd0, o_load_ready}, 32'd0);
        check("t5_rd_rst",    {24'd0, o_mem_data_read}, 32'h0);
        step();
        check("t5_done_rst",  {31'd0, o_load_done}, 32'd0);
        check("t5_hold_rst",  {31'd0, o_cpu_hold}, 32'd1);
        i_rst = 1'b0;
        step();
        check("t5_ready", {31'd0, o_load_ready}, 32'd1);
        load_byte(8'hF1, 1'b0);
        check("t5_rd_hold", {24'd0, o_mem_data_read}, 32'h0);
        load_byte(8'hF2, 1'b1);
        check("t5_done", {31'd0, o_load_done}, 32'd1);
        bus_cycle(8'h00, 1'b0, 8'h00, 1'b1, 8'hF1, "t5_rd00");
        bus_cycle(8'h01, 1'b0, 8'h00, 1'b1, 8'hF2, "t5_rd01");
        bus_cycle(8'h02, 1'b0, 8'h00, 1'b1, 8'h58, "t5_rd02");

        check("sb_empty", exp_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
